// File: rtl/validador.sv
// validador: placement validator for the naval-battle game.
// Builds the 64-bit cell mask of one requested ship placement, checks it
// against the board edges, scans the player's stored piece masks for
// overlap and, if the placement is legal, writes the mask into the next
// free slot of that player's piece memory.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   enable                request; a 0->1 edge sampled in IDLE starts a check
//   tipo, direcao,        ship type, extension direction, axis,
//   orientacao, x1, y1,   start cell and player of the placement
//   jogador
//   vetor_leitura         memory read data, valid the cycle after read_addr
//   ready                 one-cycle pulse when the check completes
//   conflitoBorda_out     edge / invalid-input conflict (held)
//   conflitoMemoria_out   overlap / memory-full conflict (held)
//   conflito              OR of both conflict flags
//   wrep1, wrep2          one-cycle write enable, player 0 / player 1 memory
//   vetor                 mask being written (held after the write)
//   read_addr             {jogador, slot}
//   write_addr            {jogador, count}
module validador #(
  parameter int unsigned BOARD      = 8,
  parameter int unsigned MAX_PIECES = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  tipo,
  input  logic        direcao,
  input  logic [2:0]  orientacao,
  input  logic [3:0]  x1,
  input  logic [3:0]  y1,
  input  logic        jogador,
  input  logic [63:0] vetor_leitura,
  output logic        ready,
  output logic        conflitoBorda_out,
  output logic        conflitoMemoria_out,
  output logic        conflito,
  output logic        wrep1,
  output logic        wrep2,
  output logic [63:0] vetor,
  output logic [4:0]  read_addr,
  output logic [4:0]  write_addr
);

  localparam int          BRD     = int'(BOARD);
  localparam int          MAX_LEN = 5;
  localparam logic [3:0]  MAX_C   = 4'(BOARD - 1);
  localparam logic [3:0]  FULL    = 4'(MAX_PIECES);

  typedef enum logic [2:0] {IDLE, CALC, ADDR, CMP, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic        en_q;
  logic [2:0]  tipo_r, tipo_n;
  logic        dir_r, dir_n;
  logic [2:0]  ori_r, ori_n;
  logic [3:0]  x_r, x_n, y_r, y_n;
  logic        jog_r, jog_n;
  logic [3:0]  slot, slot_n;
  logic [3:0]  cnt0, cnt0_n, cnt1, cnt1_n;
  logic [3:0]  cnt_sel;

  logic        ready_n, borda_n, memc_n, wrep1_n, wrep2_n;
  logic [63:0] vetor_n;
  logic [4:0]  ra_n, wa_n;

  logic [63:0] mask_c;
  logic        borda_c;

  assign cnt_sel = jog_r ? cnt1 : cnt0;

  // Ship mask and edge check from the latched placement.
  always_comb begin
    int len, cx, cy, step;
    mask_c  = '0;
    borda_c = 1'b0;
    len     = 0;
    cx      = 0;
    cy      = 0;
    step    = 0;
    case (tipo_r)
      3'd0:    len = 5;
      3'd1:    len = 4;
      3'd2:    len = 3;
      3'd3:    len = 2;
      3'd4:    len = 1;
      default: borda_c = 1'b1;
    endcase
    if (ori_r > 3'd1 || x_r > MAX_C || y_r > MAX_C) borda_c = 1'b1;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (k < len) begin
        step = dir_r ? -k : k;
        cx   = int'(x_r);
        cy   = int'(y_r);
        if (ori_r == 3'd0) cx = cx + step;
        else               cy = cy + step;
        if (cx < 0 || cx >= BRD || cy < 0 || cy >= BRD) borda_c = 1'b1;
        else mask_c[6'(cy * BRD + cx)] = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    tipo_n    = tipo_r;
    dir_n     = dir_r;
    ori_n     = ori_r;
    x_n       = x_r;
    y_n       = y_r;
    jog_n     = jog_r;
    slot_n    = slot;
    cnt0_n    = cnt0;
    cnt1_n    = cnt1;
    ready_n   = 1'b0;
    wrep1_n   = 1'b0;
    wrep2_n   = 1'b0;
    borda_n   = conflitoBorda_out;
    memc_n    = conflitoMemoria_out;
    vetor_n   = vetor;
    ra_n      = read_addr;
    wa_n      = write_addr;
    case (state)
      IDLE: begin
        if (enable && !en_q) begin
          tipo_n    = tipo;
          dir_n     = direcao;
          ori_n     = orientacao;
          x_n       = x1;
          y_n       = y1;
          jog_n     = jogador;
          borda_n   = 1'b0;
          memc_n    = 1'b0;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (borda_c) begin
          borda_n   = 1'b1;
          state_nxt = DONE;
        end else if (cnt_sel == FULL) begin
          memc_n    = 1'b1;
          state_nxt = DONE;
        end else if (cnt_sel == 4'd0) begin
          state_nxt = WRITE;
        end else begin
          // Address goes out now so memory data lines up with CMP.
          slot_n    = 4'd0;
          ra_n      = {jog_r, 4'd0};
          state_nxt = ADDR;
        end
      end
      ADDR: state_nxt = CMP;
      CMP: begin
        if ((vetor_leitura & mask_c) != 64'd0) begin
          memc_n    = 1'b1;
          state_nxt = DONE;
        end else if (slot == 4'(cnt_sel - 4'd1)) begin
          state_nxt = WRITE;
        end else begin
          slot_n    = 4'(slot + 4'd1);
          ra_n      = {jog_r, 4'(slot + 4'd1)};
          state_nxt = ADDR;
        end
      end
      WRITE: begin
        wa_n    = {jog_r, cnt_sel};
        vetor_n = mask_c;
        if (jog_r) begin
          wrep2_n = 1'b1;
          cnt1_n  = 4'(cnt1 + 4'd1);
        end else begin
          wrep1_n = 1'b1;
          cnt0_n  = 4'(cnt0 + 4'd1);
        end
        state_nxt = DONE;
      end
      DONE: begin
        ready_n   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      en_q                <= 1'b0;
      tipo_r              <= '0;
      dir_r               <= 1'b0;
      ori_r               <= '0;
      x_r                 <= '0;
      y_r                 <= '0;
      jog_r               <= 1'b0;
      slot                <= '0;
      cnt0                <= '0;
      cnt1                <= '0;
      ready               <= 1'b0;
      conflitoBorda_out   <= 1'b0;
      conflitoMemoria_out <= 1'b0;
      conflito            <= 1'b0;
      wrep1               <= 1'b0;
      wrep2               <= 1'b0;
      vetor               <= '0;
      read_addr           <= '0;
      write_addr          <= '0;
    end else begin
      state               <= state_nxt;
      en_q                <= enable;
      tipo_r              <= tipo_n;
      dir_r               <= dir_n;
      ori_r               <= ori_n;
      x_r                 <= x_n;
      y_r                 <= y_n;
      jog_r               <= jog_n;
      slot                <= slot_n;
      cnt0                <= cnt0_n;
      cnt1                <= cnt1_n;
      ready               <= ready_n;
      conflitoBorda_out   <= borda_n;
      conflitoMemoria_out <= memc_n;
      conflito            <= borda_n | memc_n;
      wrep1               <= wrep1_n;
      wrep2               <= wrep2_n;
      vetor               <= vetor_n;
      read_addr           <= ra_n;
      write_addr          <= wa_n;
    end
  end

endmodule

// File: tb/tb_validador.sv
// tb_validador: directed self-checking bench for validador.
// Drives placements, models the dual-player piece memory with a
// one-cycle read latency, and checks latencies, masks, addresses and flags.
module tb_validador;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  tipo;
  logic        direcao;
  logic [2:0]  orientacao;
  logic [3:0]  x1, y1;
  logic        jogador;
  logic [63:0] vetor_leitura;
  logic        ready, conflitoBorda_out, conflitoMemoria_out, conflito;
  logic        wrep1, wrep2;
  logic [63:0] vetor;
  logic [4:0]  read_addr, write_addr;

  int checks = 0;
  int errors = 0;

  // Results captured by place()
  int          rdy_cyc, wr_cyc, n_rdy, n_wr;
  logic [1:0]  wr_sel;
  logic [4:0]  wa, ra;
  logic [63:0] vt;
  logic        f_borda, f_mem, f_confl;

  logic [63:0] mem [32];

  validador dut (
    .clk(clk), .reset(reset), .enable(enable), .tipo(tipo),
    .direcao(direcao), .orientacao(orientacao), .x1(x1), .y1(y1),
    .jogador(jogador), .vetor_leitura(vetor_leitura), .ready(ready),
    .conflitoBorda_out(conflitoBorda_out),
    .conflitoMemoria_out(conflitoMemoria_out), .conflito(conflito),
    .wrep1(wrep1), .wrep2(wrep2), .vetor(vetor),
    .read_addr(read_addr), .write_addr(write_addr)
  );

  always #5 clk = ~clk;

  // Piece memory: synchronous write, one-cycle registered read.
  always @(posedge clk) begin
    if (wrep1 || wrep2) mem[write_addr] <= vetor;
    vetor_leitura <= mem[read_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One placement; cycle numbers count edges after the sampling edge.
  task automatic place(input logic [2:0] t, input logic [3:0] x, input logic [3:0] y,
                       input logic [2:0] o, input logic d, input logic j, input bit hold);
    @(negedge clk);
    tipo = t; x1 = x; y1 = y; orientacao = o; direcao = d; jogador = j;
    enable = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) enable = 1'b0;
    rdy_cyc = -1; wr_cyc = -1; n_rdy = 0; n_wr = 0;
    wr_sel = 2'b00; wa = '0; vt = '0; ra = '0;
    f_borda = 1'b0; f_mem = 1'b0; f_confl = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) ra = read_addr;
      if (ready) begin
        n_rdy++;
        if (rdy_cyc < 0) begin
          rdy_cyc = k;
          f_borda = conflitoBorda_out;
          f_mem   = conflitoMemoria_out;
          f_confl = conflito;
        end
      end
      if (wrep1 || wrep2) begin
        n_wr++;
        wr_cyc = k;
        wr_sel = {wrep2, wrep1};
        wa     = write_addr;
        vt     = vetor;
      end
    end
    enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int x, y, n_ab;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    reset = 1'b1; enable = 1'b0; tipo = '0; direcao = 1'b0; orientacao = '0;
    x1 = '0; y1 = '0; jogador = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_wrep", 64'({wrep1, wrep2}), 64'd0);
    chk("rst_conflito", 64'({conflito, conflitoBorda_out, conflitoMemoria_out}), 64'd0);
    chk("rst_vetor", vetor, 64'd0);
    chk("rst_addr", 64'({read_addr, write_addr}), 64'd0);
    reset = 1'b0;

    // Edge conflict: carrier from x=7 going right
    place(3'd0, 4'd7, 4'd0, 3'd0, 1'b0, 1'b0, 0);
    chk("edge_rdy_cyc", 64'(rdy_cyc), 64'd2);
    chk("edge_borda", 64'({f_borda, f_confl, f_mem}), 64'b110);
    chk("edge_nwr", 64'(n_wr), 64'd0);

    // First write, empty memory
    place(3'd0, 4'd1, 4'd1, 3'd0, 1'b0, 1'b0, 0);
    chk("w1_wr_cyc", 64'(wr_cyc), 64'd2);
    chk("w1_sel", 64'(wr_sel), 64'b01);
    chk("w1_wa", 64'(wa), 64'd0);
    chk("w1_vetor", vt, 64'h3E00);
    chk("w1_rdy_cyc", 64'(rdy_cyc), 64'd3);
    chk("w1_confl", 64'(f_confl), 64'd0);

    // Overlap with the stored carrier
    place(3'd1, 4'd1, 4'd1, 3'd0, 1'b0, 1'b0, 0);
    chk("ov_ra", 64'(ra), 64'd0);
    chk("ov_flags", 64'({f_borda, f_mem, f_confl}), 64'b011);
    chk("ov_nwr", 64'(n_wr), 64'd0);
    chk("ov_rdy_cyc", 64'(rdy_cyc), 64'd4);

    // Player 1, vertical, negative; enable held high must not retrigger
    place(3'd2, 4'd2, 4'd5, 3'd1, 1'b1, 1'b1, 1);
    chk("p1_sel", 64'(wr_sel), 64'b10);
    chk("p1_wa", 64'(wa), 64'd16);
    chk("p1_vetor", vt, 64'h0000_0404_0400_0000);
    chk("p1_wr_cyc", 64'(wr_cyc), 64'd2);
    chk("p1_nrdy", 64'(n_rdy), 64'd1);
    chk("p1_confl", 64'(f_confl), 64'd0);

    // Same ship from y=1 going up leaves the board
    place(3'd2, 4'd2, 4'd1, 3'd1, 1'b1, 1'b1, 0);
    chk("p1edge_flags", 64'({f_borda, f_mem}), 64'b10);
    chk("p1edge_rdy", 64'(rdy_cyc), 64'd2);
    chk("p1edge_nwr", 64'(n_wr), 64'd0);

    // Fill player 0 with submarines on rows 7 and 6
    for (int i = 0; i < 10; i++) begin
      x = (i < 8) ? i : i - 8;
      y = (i < 8) ? 7 : 6;
      place(3'd4, 4'(x), 4'(y), 3'd0, 1'b0, 1'b0, 0);
      chk("fill_wa", 64'(wa), 64'(i + 1));
      chk("fill_wr_cyc", 64'(wr_cyc), 64'(2 + 2 * (i + 1)));
      chk("fill_vetor", vt, 64'd1 << (y * 8 + x));
      chk("fill_rdy", 64'(rdy_cyc), 64'(3 + 2 * (i + 1)));
    end

    // Twelfth piece: memory full
    place(3'd4, 4'd5, 4'd5, 3'd0, 1'b0, 1'b0, 0);
    chk("full_flags", 64'({f_borda, f_mem, f_confl}), 64'b011);
    chk("full_rdy", 64'(rdy_cyc), 64'd2);
    chk("full_nwr", 64'(n_wr), 64'd0);

    // Reset while player 1 is being scanned
    @(negedge clk);
    tipo = 3'd4; x1 = 4'd7; y1 = 4'd7; orientacao = 3'd0; direcao = 1'b0; jogador = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    n_ab = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) reset = 1'b0;
      if (ready || wrep1 || wrep2) n_ab++;
    end
    chk("abort_pulses", 64'(n_ab), 64'd0);
    chk("abort_outs", 64'({conflito, read_addr, write_addr}), 64'd0);

    // Counters cleared by reset
    place(3'd0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 0);
    chk("post_wa", 64'(wa), 64'd0);
    chk("post_wr_cyc", 64'(wr_cyc), 64'd2);
    chk("post_vetor", vt, 64'h1F);
    place(3'd3, 4'd6, 4'd0, 3'd0, 1'b1, 1'b1, 0);
    chk("post_p1_wa", 64'(wa), 64'd16);
    chk("post_p1_vetor", vt, 64'h60);
    chk("post_p1_wr_cyc", 64'(wr_cyc), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
